// File: rtl/vx_smem_arb_pkg.sv
// Shared-memory arbiter package: default configuration, tag layout and lane payload.
// Perf counters (SMEM_ARB_PERF_EN) use `PERF_CTR_BITS, defaulted here when not set.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package vx_smem_arb_pkg;

  localparam int SMEM_NUM_INPUTS   = 2;
  localparam int SMEM_NUM_REQS     = 4;
  localparam int SMEM_WORD_SIZE    = 4;
  localparam int SMEM_ADDR_WIDTH   = 30;
  localparam int SMEM_TAG_IN_WIDTH = 10;

  function automatic int log_inputs(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requester index occupies the tag LSBs on the shared-memory side.
  localparam int TAG_IDX_LSB        = 0;
  localparam int TAG_IDX_WIDTH      = log_inputs(SMEM_NUM_INPUTS);
  localparam int SMEM_TAG_OUT_WIDTH = SMEM_TAG_IN_WIDTH + TAG_IDX_WIDTH;

  typedef struct packed {
    logic                          rw;
    logic [SMEM_ADDR_WIDTH-1:0]    addr;
    logic [SMEM_WORD_SIZE-1:0]     byteen;
    logic [SMEM_WORD_SIZE*8-1:0]   data;
    logic [SMEM_TAG_OUT_WIDTH-1:0] tag;
  } smem_req_t;

endpackage

// File: rtl/vx_smem_arb_if.sv
// Requester-side and shared-memory-side buses of the shared-memory arbiter.
// slave = arbiter view, master = requesters plus shared memory.
interface vx_smem_arb_if
  import vx_smem_arb_pkg::*;
#(
  parameter int NUM_INPUTS   = SMEM_NUM_INPUTS,
  parameter int NUM_REQS     = SMEM_NUM_REQS,
  parameter int WORD_SIZE    = SMEM_WORD_SIZE,
  parameter int ADDR_WIDTH   = SMEM_ADDR_WIDTH,
  parameter int TAG_IN_WIDTH = SMEM_TAG_IN_WIDTH
);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + log_inputs(NUM_INPUTS);

  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                   in_req_valid;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                   in_req_rw;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][ADDR_WIDTH-1:0]   in_req_addr;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][WORD_SIZE-1:0]    in_req_byteen;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][WORD_SIZE*8-1:0]  in_req_data;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][TAG_IN_WIDTH-1:0] in_req_tag;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                   in_req_ready;

  logic [NUM_REQS-1:0]                    out_req_valid;
  logic [NUM_REQS-1:0]                    out_req_rw;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    out_req_addr;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]     out_req_byteen;
  logic [NUM_REQS-1:0][WORD_SIZE*8-1:0]   out_req_data;
  logic [NUM_REQS-1:0][TAG_OUT_WIDTH-1:0] out_req_tag;
  logic [NUM_REQS-1:0]                    out_req_ready;

  logic                                 out_rsp_valid;
  logic [NUM_REQS-1:0]                  out_rsp_tmask;
  logic [NUM_REQS-1:0][WORD_SIZE*8-1:0] out_rsp_data;
  logic [TAG_OUT_WIDTH-1:0]             out_rsp_tag;
  logic                                 out_rsp_ready;

  logic [NUM_INPUTS-1:0]                                in_rsp_valid;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                  in_rsp_tmask;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][WORD_SIZE*8-1:0] in_rsp_data;
  logic [NUM_INPUTS-1:0][TAG_IN_WIDTH-1:0]              in_rsp_tag;
  logic [NUM_INPUTS-1:0]                                in_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    output in_req_ready,
    output out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    input  out_req_ready,
    input  out_rsp_valid, out_rsp_tmask, out_rsp_data, out_rsp_tag,
    output out_rsp_ready,
    output in_rsp_valid, in_rsp_tmask, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    input  in_req_ready,
    input  out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    output out_req_ready,
    output out_rsp_valid, out_rsp_tmask, out_rsp_data, out_rsp_tag,
    input  out_rsp_ready,
    input  in_rsp_valid, in_rsp_tmask, in_rsp_data, in_rsp_tag,
    output in_rsp_ready
  );

endinterface

// File: rtl/vx_smem_arb_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the grant is consumed (enable).
module vx_smem_arb_rr
  import vx_smem_arb_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_W      = log_inputs(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] requests,
  input  logic                  enable,
  output logic [NUM_INPUTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]      grant_index,
  output logic                  grant_valid
);

  logic [IDX_W-1:0]                  ptr_reg;
  logic [NUM_INPUTS-1:0][IDX_W-1:0]  cand_idx;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(ptr_reg) + gi) % NUM_INPUTS);
  end

  always_comb begin
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!grant_valid && requests[cand_idx[k]]) begin
        grant_valid = 1'b1;
        grant_index = cand_idx[k];
      end
    end
    if (grant_valid) grant_onehot[grant_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (enable && grant_valid) begin
      ptr_reg <= (grant_index == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vx_smem_arb.sv
// Shares one shared-memory core port among NUM_INPUTS requesters: round-robin per
// lane-vector, registered request, index-tagged responses. Optional: SMEM_ARB_PERF_EN.
module vx_smem_arb
  import vx_smem_arb_pkg::*;
#(
  parameter int NUM_INPUTS   = SMEM_NUM_INPUTS,
  parameter int NUM_REQS     = SMEM_NUM_REQS,
  parameter int WORD_SIZE    = SMEM_WORD_SIZE,
  parameter int ADDR_WIDTH   = SMEM_ADDR_WIDTH,
  parameter int TAG_IN_WIDTH = SMEM_TAG_IN_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  vx_smem_arb_if.slave bus
`ifdef SMEM_ARB_PERF_EN
  ,
  output logic [NUM_INPUTS-1:0][`PERF_CTR_BITS-1:0] perf_arb_stalls
`endif
);

  localparam int LOG_NI        = log_inputs(NUM_INPUTS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NI;

  if (NUM_INPUTS < 2) begin : g_bad_inputs
    $error("vx_smem_arb: NUM_INPUTS must be >= 2");
  end
  if (NUM_INPUTS != SMEM_NUM_INPUTS || NUM_REQS != SMEM_NUM_REQS || WORD_SIZE != SMEM_WORD_SIZE
      || ADDR_WIDTH != SMEM_ADDR_WIDTH || TAG_IN_WIDTH != SMEM_TAG_IN_WIDTH) begin : g_bad_cfg
    $error("vx_smem_arb: parameters must match vx_smem_arb_pkg payload layout");
  end

  logic [NUM_INPUTS-1:0] active;
  logic [NUM_INPUTS-1:0] grant_onehot;
  logic [LOG_NI-1:0]     grant_index;
  logic                  grant_valid;
  logic                  load;
  logic [NUM_REQS-1:0]   pend_mask_reg;
  logic [NUM_REQS-1:0]   lane_left;
  smem_req_t             req_reg [NUM_REQS];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_active
    assign active[gi] = |bus.in_req_valid[gi];
  end

  // A new transaction may load while the last pending lanes are leaving.
  assign lane_left = pend_mask_reg & ~bus.out_req_ready;
  assign load      = ~reset & (lane_left == '0) & grant_valid;

  vx_smem_arb_rr #(.NUM_INPUTS(NUM_INPUTS)) u_rr (
    .clk          (clk),
    .reset        (reset),
    .requests     (active),
    .enable       (load),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in_ready
    assign bus.in_req_ready[gi] = (load && grant_onehot[gi]) ? bus.in_req_valid[gi] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_mask_reg <= '0;
    end else if (load) begin
      pend_mask_reg <= bus.in_req_valid[grant_index];
    end else begin
      pend_mask_reg <= lane_left;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int l = 0; l < NUM_REQS; l++) begin
        req_reg[l].rw     <= bus.in_req_rw[grant_index][l];
        req_reg[l].addr   <= bus.in_req_addr[grant_index][l];
        req_reg[l].byteen <= bus.in_req_byteen[grant_index][l];
        req_reg[l].data   <= bus.in_req_data[grant_index][l];
        req_reg[l].tag    <= {bus.in_req_tag[grant_index][l], grant_index};
      end
    end
  end

  assign bus.out_req_valid = pend_mask_reg;
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_out_req
    assign bus.out_req_rw[gi]     = req_reg[gi].rw;
    assign bus.out_req_addr[gi]   = req_reg[gi].addr;
    assign bus.out_req_byteen[gi] = req_reg[gi].byteen;
    assign bus.out_req_data[gi]   = req_reg[gi].data;
    assign bus.out_req_tag[gi]    = req_reg[gi].tag;
  end

  // Response routing: unused index codes (non power-of-two inputs) are swallowed.
  logic [LOG_NI-1:0]        rsp_sel;
  logic [(1<<LOG_NI)-1:0]   sel_ok_map;
  logic                     rsp_sel_ok;

  assign rsp_sel = bus.out_rsp_tag[TAG_IDX_LSB +: LOG_NI];
  for (genvar gi = 0; gi < (1 << LOG_NI); gi++) begin : g_sel_ok
    assign sel_ok_map[gi] = (gi < NUM_INPUTS);
  end
  assign rsp_sel_ok = sel_ok_map[rsp_sel];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in_rsp
    assign bus.in_rsp_valid[gi] = bus.out_rsp_valid & rsp_sel_ok & (rsp_sel == LOG_NI'(gi));
    assign bus.in_rsp_tmask[gi] = bus.out_rsp_tmask;
    assign bus.in_rsp_data[gi]  = bus.out_rsp_data;
    assign bus.in_rsp_tag[gi]   = bus.out_rsp_tag[TAG_OUT_WIDTH-1:LOG_NI];
  end
  assign bus.out_rsp_ready = rsp_sel_ok ? bus.in_rsp_ready[rsp_sel] : 1'b1;

  assert property (@(posedge clk) disable iff (reset) bus.out_rsp_valid |-> rsp_sel_ok);

`ifdef SMEM_ARB_PERF_EN
  localparam int CTR_W = `PERF_CTR_BITS;
  logic [NUM_INPUTS-1:0][CTR_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (reset) begin
        stall_cnt_reg[i] <= '0;
      end else if (active[i] && !(load && grant_onehot[i])) begin
        stall_cnt_reg[i] <= stall_cnt_reg[i] + CTR_W'(1);
      end
    end
  end
  assign perf_arb_stalls = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vx_smem_arb.sv
// Self-checking bench for vx_smem_arb: response table, directed corner sequences,
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_vx_smem_arb;
  import vx_smem_arb_pkg::*;

  localparam int NI = 2, NR = 4, WS = 4, AW = 30, TIW = 10, TOW = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_smem_arb_if #(.NUM_INPUTS(NI), .NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW),
                   .TAG_IN_WIDTH(TIW)) bus ();
`ifdef SMEM_ARB_PERF_EN
  logic [NI-1:0][`PERF_CTR_BITS-1:0] perf;
`endif

  vx_smem_arb #(.NUM_INPUTS(NI), .NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW),
                .TAG_IN_WIDTH(TIW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SMEM_ARB_PERF_EN
    , .perf_arb_stalls (perf)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           valid;
    logic [TOW-1:0] tag;
    logic [1:0]     rdy;
    logic [1:0]     exp_v;
    logic [TIW-1:0] exp_tag;
    logic           exp_ready;
  } rsp_vec_t;
  rsp_vec_t rtab [8];

  // reference model state: one in-flight transaction plus a round-robin pointer
  int             m_ptr;
  logic [NR-1:0]  m_mask;
  logic [NR-1:0]  rem;
  logic [34:0]    m_ctl [NR];
  logic [31:0]    m_data [NR];
  logic [TOW-1:0] m_tag [NR];
  int             g, idx, s;
  logic           do_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_req_valid  = '0;
    bus.in_req_rw     = '0;
    bus.in_req_addr   = '0;
    bus.in_req_byteen = '0;
    bus.in_req_data   = '0;
    bus.in_req_tag    = '0;
    bus.out_req_ready = '0;
    bus.out_rsp_valid = 1'b0;
    bus.out_rsp_tmask = '0;
    bus.out_rsp_data  = '0;
    bus.out_rsp_tag   = '0;
    bus.in_rsp_ready  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [NR-1:0] lanes, input int base);
    for (int l = 0; l < NR; l++) begin
      bus.in_req_valid[i][l]  = lanes[l];
      bus.in_req_rw[i][l]     = 1'b0;
      bus.in_req_addr[i][l]   = AW'(base + l);
      bus.in_req_byteen[i][l] = 4'hF;
      bus.in_req_data[i][l]   = 32'(base * 16 + l);
      bus.in_req_tag[i][l]    = TIW'(base + l);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rtab[0] = '{1'b1, 11'h055, 2'b00, 2'b10, 10'h02A, 1'b0};
    rtab[1] = '{1'b1, 11'h055, 2'b10, 2'b10, 10'h02A, 1'b1};
    rtab[2] = '{1'b1, 11'h055, 2'b01, 2'b10, 10'h02A, 1'b0};
    rtab[3] = '{1'b1, 11'h7FE, 2'b01, 2'b01, 10'h3FF, 1'b1};
    rtab[4] = '{1'b1, 11'h7FE, 2'b10, 2'b01, 10'h3FF, 1'b0};
    rtab[5] = '{1'b0, 11'h055, 2'b11, 2'b00, 10'h02A, 1'b1};
    rtab[6] = '{1'b1, 11'h401, 2'b01, 2'b10, 10'h200, 1'b0};
    rtab[7] = '{1'b1, 11'h000, 2'b11, 2'b01, 10'h000, 1'b1};

    idle_inputs();
    do_reset();

    // reset state with no requests
    #2;
    chk("reset out_req_valid", 64'(bus.out_req_valid), 64'(0));
    chk("reset in_req_ready", 64'(bus.in_req_ready), 64'(0));
    tick();

    // response routing table
    for (int i = 0; i < 8; i++) begin
      bus.out_rsp_valid = rtab[i].valid;
      bus.out_rsp_tag   = rtab[i].tag;
      bus.in_rsp_ready  = rtab[i].rdy;
      bus.out_rsp_tmask = 4'(i + 5);
      bus.out_rsp_data[0] = 32'hA5A5_0000 + 32'(i);
      #2;
      $display("rsp vec %0d tag=%0h rdy=%b -> in_rsp_valid=%b tag=%0h ready=%b", i,
               rtab[i].tag, rtab[i].rdy, bus.in_rsp_valid, bus.in_rsp_tag[1], bus.out_rsp_ready);
      chk("rsp in_valid", 64'(bus.in_rsp_valid), 64'(rtab[i].exp_v));
      chk("rsp tag0", 64'(bus.in_rsp_tag[0]), 64'(rtab[i].exp_tag));
      chk("rsp tag1", 64'(bus.in_rsp_tag[1]), 64'(rtab[i].exp_tag));
      chk("rsp out_ready", 64'(bus.out_rsp_ready), 64'(rtab[i].exp_ready));
      chk("rsp tmask bcast", 64'(bus.in_rsp_tmask[1]), 64'(i + 5));
      chk("rsp data bcast", 64'(bus.in_rsp_data[0][0]), 64'(32'hA5A5_0000 + 32'(i)));
      tick();
    end
    idle_inputs();

    // both inputs full reads every cycle: grants alternate, one transaction per cycle
    do_reset();
    set_req(0, 4'hF, 'h100);
    set_req(1, 4'hF, 'h200);
    bus.out_req_ready = '1;
    for (int c = 0; c < 6; c++) begin
      #2;
      $display("alt cycle %0d ready0=%h ready1=%h out_valid=%h", c,
               bus.in_req_ready[0], bus.in_req_ready[1], bus.out_req_valid);
      chk("alt ready0", 64'(bus.in_req_ready[0]), 64'((c % 2 == 0) ? 4'hF : 4'h0));
      chk("alt ready1", 64'(bus.in_req_ready[1]), 64'((c % 2 == 1) ? 4'hF : 4'h0));
      if (c > 0) begin
        chk("alt out_valid", 64'(bus.out_req_valid), 64'(4'hF));
        chk("alt tag lane3", 64'(bus.out_req_tag[3]),
            64'(((((c - 1) % 2 == 0) ? 'h100 : 'h200) + 3) * 2 + ((c - 1) % 2)));
      end
      tick();
    end
    idle_inputs();

    // partial lanes, lane2 back-pressured for 3 cycles
    do_reset();
    set_req(0, 4'b0101, 'h300);
    bus.out_req_ready = 4'b1011;
    #2;
    chk("hold load ready0", 64'(bus.in_req_ready[0]), 64'(4'b0101));
    tick();
    set_req(0, 4'b0011, 'h340);
    for (int c = 1; c <= 3; c++) begin
      #2;
      $display("hold cycle %0d out_valid=%b ready0=%b", c, bus.out_req_valid, bus.in_req_ready[0]);
      chk("hold out_valid", 64'(bus.out_req_valid), 64'((c == 1) ? 4'b0101 : 4'b0100));
      chk("hold addr2", 64'(bus.out_req_addr[2]), 64'('h302));
      chk("hold data2", 64'(bus.out_req_data[2]), 64'('h3002));
      chk("hold no load", 64'(bus.in_req_ready[0]), 64'(0));
      tick();
    end
    bus.out_req_ready = 4'b1111;
    #2;
    chk("hold last lane", 64'(bus.out_req_valid), 64'(4'b0100));
    chk("hold b2b load", 64'(bus.in_req_ready[0]), 64'(4'b0011));
    tick();
    idle_inputs();
    #2;
    chk("hold next valid", 64'(bus.out_req_valid), 64'(4'b0011));
    chk("hold next addr0", 64'(bus.out_req_addr[0]), 64'('h340));
    chk("hold next tag1", 64'(bus.out_req_tag[1]), 64'('h341 * 2));
    tick();

    // reset while lanes are pending
    do_reset();
    set_req(0, 4'b0011, 'h50);
    #2;
    chk("rst load ready0", 64'(bus.in_req_ready[0]), 64'(4'b0011));
    tick();
    idle_inputs();
    #2;
    chk("rst pending", 64'(bus.out_req_valid), 64'(4'b0011));
    tick();
    reset = 1'b1;
    set_req(0, 4'hF, 'h60);
    set_req(1, 4'hF, 'h70);
    #2;
    chk("rst no ready0", 64'(bus.in_req_ready[0]), 64'(0));
    chk("rst no ready1", 64'(bus.in_req_ready[1]), 64'(0));
    tick();
    reset = 1'b0;
    #2;
    $display("reset-mid out_valid=%b ready0=%h ready1=%h", bus.out_req_valid,
             bus.in_req_ready[0], bus.in_req_ready[1]);
    chk("rst dropped", 64'(bus.out_req_valid), 64'(0));
    chk("rst ptr0 ready0", 64'(bus.in_req_ready[0]), 64'(4'hF));
    chk("rst ptr0 ready1", 64'(bus.in_req_ready[1]), 64'(0));
    tick();
    idle_inputs();

`ifdef SMEM_ARB_PERF_EN
    // input1 blocked for 5 cycles behind input0
    do_reset();
    #2;
    chk("perf reset1", 64'(perf[1]), 64'(0));
    set_req(0, 4'b0001, 'h10);
    set_req(1, 4'b0001, 'h20);
    chk("perf grant0", 64'(bus.in_req_ready[0]), 64'(4'b0001));
    tick();
    bus.in_req_valid[0] = '0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      chk("perf blocked", 64'(bus.in_req_ready[1]), 64'(0));
      tick();
    end
    bus.out_req_ready = '1;
    #2;
    chk("perf grant1", 64'(bus.in_req_ready[1]), 64'(4'b0001));
    tick();
    idle_inputs();
    #2;
    $display("perf stalls0=%0d stalls1=%0d", perf[0], perf[1]);
    chk("perf stalls1", 64'(perf[1]), 64'(5));
    chk("perf stalls0", 64'(perf[0]), 64'(0));
    tick();
`endif

    // randomized traffic against the reference model
    do_reset();
    m_ptr  = 0;
    m_mask = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      do_rst = ($urandom_range(0, 59) == 0);
      reset  = do_rst;
      for (int i = 0; i < NI; i++) begin
        for (int l = 0; l < NR; l++) begin
          bus.in_req_valid[i][l]  = ($urandom_range(0, 2) == 0);
          bus.in_req_rw[i][l]     = 1'($urandom);
          bus.in_req_addr[i][l]   = AW'($urandom);
          bus.in_req_byteen[i][l] = WS'($urandom);
          bus.in_req_data[i][l]   = 32'($urandom);
          bus.in_req_tag[i][l]    = TIW'($urandom);
        end
      end
      for (int l = 0; l < NR; l++) bus.out_req_ready[l] = ($urandom_range(0, 3) != 0);
      bus.out_rsp_valid = 1'($urandom);
      bus.out_rsp_tag   = TOW'($urandom);
      bus.out_rsp_tmask = NR'($urandom);
      bus.out_rsp_data[2] = 32'($urandom);
      bus.in_rsp_ready  = NI'($urandom);
      #2;

      rem = m_mask & ~bus.out_req_ready;
      g = -1;
      if (!do_rst && rem == '0) begin
        for (int k = 0; k < NI; k++) begin
          idx = (m_ptr + k) % NI;
          if (g < 0 && bus.in_req_valid[idx] != '0) g = idx;
        end
      end
      for (int i = 0; i < NI; i++)
        chk("rnd in_ready", 64'(bus.in_req_ready[i]), 64'((g == i) ? bus.in_req_valid[i] : '0));
      chk("rnd out_valid", 64'(bus.out_req_valid), 64'(m_mask));
      for (int l = 0; l < NR; l++) begin
        if (m_mask[l]) begin
          chk("rnd ctl", 64'({bus.out_req_rw[l], bus.out_req_byteen[l], bus.out_req_addr[l]}),
              64'(m_ctl[l]));
          chk("rnd data", 64'(bus.out_req_data[l]), 64'(m_data[l]));
          chk("rnd tag", 64'(bus.out_req_tag[l]), 64'(m_tag[l]));
        end
      end
      s = int'(bus.out_rsp_tag[0]);
      chk("rnd rsp valid", 64'(bus.in_rsp_valid),
          64'(bus.out_rsp_valid ? (2'b01 << s) : 2'b00));
      chk("rnd rsp tag", 64'(bus.in_rsp_tag[s]), 64'(bus.out_rsp_tag >> 1));
      chk("rnd rsp ready", 64'(bus.out_rsp_ready), 64'(bus.in_rsp_ready[s]));
      chk("rnd rsp data", 64'(bus.in_rsp_data[1 - s][2]), 64'(bus.out_rsp_data[2]));

      if (do_rst) begin
        m_mask = '0;
        m_ptr  = 0;
      end else if (g >= 0) begin
        m_mask = bus.in_req_valid[g];
        for (int l = 0; l < NR; l++) begin
          m_ctl[l]  = {bus.in_req_rw[g][l], bus.in_req_byteen[g][l], bus.in_req_addr[g][l]};
          m_data[l] = bus.in_req_data[g][l];
          m_tag[l]  = {bus.in_req_tag[g][l], 1'(g)};
        end
        m_ptr = (g + 1) % NI;
      end else begin
        m_mask = rem;
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
